dcnt_pwm_burst: RTL
===================

// Module: dcnt_pwm_burst
// PURPOSE
//   Downstream consumer of the 8-bit free-running down counter (FF->00, wraps).
//   Compares the live count against a duty value to drive a PWM output.
//   Emits one terminal-count pulse per 256-cycle period.
//   Runs bursts of N whole periods under a go/done control FSM.
//   Duty updates are double-buffered and take effect only at period boundaries.
// PARAMETERS
//   W          8      count/duty/burst width (whole spec assumes W=8; period = 2**W cycles)
// PORTS
//   clock       in   1   rising-edge clock, shared with the down counter
//   start       in   1   async active-high reset (same net that presets the counter to FF)
//   count       in   W   live down-counter value
//   duty_in     in   W   requested duty: number of high cycles per period
//   duty_valid  in   1   duty_in offered
//   duty_ready  out  1   shadow register free (= !pending)
//   go          in   1   1-cycle request to start a burst; honoured only in IDLE
//   burst_len   in   W   periods per burst, sampled on go; 0 = continuous
//   pwm         out  1   registered PWM output
//   tc_pulse    out  1   registered 1-cycle pulse, the cycle after count==00
//   busy        out  1   state is ARM or RUN
//   done        out  1   1-cycle pulse when a finite burst completes
//   burst_cnt   out  W   completed periods in the current or last burst
// BEHAVIOUR
//   Reset (async, start=1), applied immediately including mid-burst:
//     state=IDLE; pwm=0; tc_pulse=0; done=0; burst_cnt=0
//     duty_active=0; duty_shadow=0; pending=0; duty_ready=1; busy=0
//   Boundary: a cycle in which sampled count==8'h00.
//   tc_pulse <= (count==00), in every state.
//   pwm <= (state==RUN) && (count < duty_active)
//     - 1-cycle latency from count.
//     - Each RUN period is high for the last duty_active cycles.
//     - duty=00 gives always low; max duty FF gives 255/256 high (no 100%).
//   Duty handshake:
//     - An accept is duty_valid && duty_ready.
//     - Accept on a non-boundary cycle: duty_shadow <= duty_in; pending <= 1.
//     - Boundary with pending=1: duty_active <= duty_shadow; pending <= 0.
//     - Accept on a boundary cycle (pending is 0 there, since ready=1):
//       duty_active <= duty_in directly; pending stays 0.
//     - The period ending at a boundary always uses the old duty_active.
//     - Handshake operates in all FSM states.
//   FSM states: IDLE, ARM, RUN, DONE.
//     IDLE: go=1 -> burst_target <= burst_len; burst_cnt <= 0; go to ARM.
//     ARM:  pwm low; at boundary go to RUN, so RUN starts at count=FF.
//     RUN:  at each boundary, burst_cnt <= burst_cnt+1 (wraps FF->00).
//           If burst_target!=0 and burst_cnt+1==burst_target, go to DONE.
//     DONE: done=1 for exactly one cycle, then IDLE. burst_cnt holds its value.
//   go is ignored in ARM, RUN and DONE; there is no abort other than start.
//   Continuous mode (burst_len=0): RUN forever, burst_cnt wraps, done never fires.
//   busy is decoded from the state register; done is registered.
// TESTING
//   1 start=1 mid-RUN with pwm high -> all outputs go to reset values without a clock edge;
//     duty_ready=1.
//   2 duty 0x40 accepted in IDLE, go with burst_len=2 -> busy until FSM reaches DONE;
//     2 periods of pwm high for 64 cycles each (count 3F..00, seen +1 cycle);
//     done pulses once; burst_cnt=2.
//   3 running duty 0x40, accept 0x80 at count=0xA0 -> duty_ready=0 until the boundary;
//     current period 64 high; next period 128 high.
//   4 duty_valid with 0x10 exactly at count==00 -> accepted, duty_ready stays 1;
//     next period 16 high.
//   5 burst_len=0, duty 0xFF -> pwm low only 1 cycle per period; tc_pulse every 256 cycles;
//     burst_cnt 0xFF->0x00 after 256 periods; done never asserted.
//   6 go pulsed during ARM/RUN -> ignored: burst_target unchanged, no restart,
//     burst_cnt continues.

Source files
------------

// File: rtl/dcnt_pwm_burst.sv
// -----------------------------------------------------------------------------
// dcnt_pwm_burst
//
// Purpose
//   Consumer of an external free-running W-bit down counter (FF -> 00, wraps).
//   The block compares the live count against an active duty value to produce
//   a registered PWM output. It also emits one terminal-count pulse per period
//   and runs bursts of whole periods under a go/done control FSM.
//
//   Duty updates are double-buffered. An accepted duty value is parked in a
//   shadow register and promoted to the active register only at a period
//   boundary, which is the cycle in which the sampled count is zero. As a
//   result, the period that ends at a boundary always uses the old duty.
//
// Ports
//   clock       in   1  rising-edge clock, shared with the down counter
//   start       in   1  asynchronous active-high reset (also presets the counter)
//   count       in   W  live down-counter value
//   duty_in     in   W  requested duty (high cycles per period)
//   duty_valid  in   1  duty_in offered
//   duty_ready  out  1  shadow register free
//   go          in   1  burst request, honoured only in IDLE
//   burst_len   in   W  periods per burst, sampled on go; 0 = continuous
//   pwm         out  1  registered PWM output
//   tc_pulse    out  1  registered pulse, the cycle after count == 0
//   busy        out  1  FSM is in ARM or RUN
//   done        out  1  one-cycle pulse when a finite burst completes
//   burst_cnt   out  W  completed periods in the current or last burst
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for go
//   ARM    | burst requested, pwm held low until the next boundary
//   RUN    | pwm active, one burst_cnt increment per boundary
//   DONE   | finite burst finished, done high for this single cycle
// -----------------------------------------------------------------------------
module dcnt_pwm_burst #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         start,
  input  logic [W-1:0] count,
  input  logic [W-1:0] duty_in,
  input  logic         duty_valid,
  output logic         duty_ready,
  input  logic         go,
  input  logic [W-1:0] burst_len,
  output logic         pwm,
  output logic         tc_pulse,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] burst_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [W-1:0] CNT_ZERO = '0;
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [1:0]   state;
  logic [1:0]   state_nxt;

  logic [W-1:0] duty_active;
  logic [W-1:0] duty_shadow;
  logic         pending;

  logic [W-1:0] burst_target;
  logic [W-1:0] cnt_inc;

  logic         boundary;
  logic         accept;
  logic         last_period;
  logic         in_run;

  // ---------------------------------------------------------------------------
  // Decodes
  // ---------------------------------------------------------------------------
  assign boundary   = (count == CNT_ZERO);
  assign duty_ready = ~pending;
  assign accept     = duty_valid & duty_ready;
  assign in_run     = (state == S_RUN);
  assign busy       = (state == S_ARM) | (state == S_RUN);

  // The increment wraps naturally at W bits. A target of zero therefore never
  // matches, because continuous mode is excluded explicitly.
  assign cnt_inc     = burst_cnt + CNT_ONE;
  assign last_period = (burst_target != CNT_ZERO) && (cnt_inc == burst_target);

  // ---------------------------------------------------------------------------
  // Duty double buffer
  //
  // accept implies pending == 0. At a boundary, at most one of the promotion
  // path and the direct-load path can be taken.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      duty_active <= '0;
      duty_shadow <= '0;
      pending     <= 1'b0;
    end else if (boundary) begin
      if (pending) begin
        duty_active <= duty_shadow;
        pending     <= 1'b0;
      end else if (accept) begin
        // Accept on the boundary itself: the new value applies to the
        // period starting next cycle, so the shadow stage is bypassed.
        duty_active <= duty_in;
      end
    end else if (accept) begin
      duty_shadow <= duty_in;
      pending     <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        // Leaving ARM on the boundary means RUN always begins at count == FF.
        if (boundary) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (boundary && last_period) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Burst target and completed-period counter.
  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      burst_target <= '0;
      burst_cnt    <= '0;
    end else if ((state == S_IDLE) && go) begin
      burst_target <= burst_len;
      burst_cnt    <= '0;
    end else if (in_run && boundary) begin
      burst_cnt <= cnt_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      pwm      <= 1'b0;
      tc_pulse <= 1'b0;
      done     <= 1'b0;
    end else begin
      tc_pulse <= boundary;
      // A strict less-than gives the last duty_active counts of each period,
      // so the maximum duty still leaves one low cycle per period.
      pwm      <= in_run && (count < duty_active);
      // done is set on the RUN->DONE transition, so it is high exactly while
      // the state register holds DONE.
      done     <= in_run && boundary && last_period;
    end
  end

endmodule
